seg7_mux_display: RTL and testbench
===================================

SEG7_MUX_DISPLAY -- requirements
Module: seg7_mux_display

Interface
REQ-001 SHALL have parameter clk_mhz, default 50, system clock frequency in MHz (documentation only).
REQ-002 SHALL have parameter w_digit, default 8, number of multiplexed digits (2..8).
REQ-003 SHALL have parameter w_value, default 16, binary input width (4..27).
REQ-004 SHALL have parameter slot_cycles, default 5000, clock cycles each digit stays selected (>= blank_cycles + 2).
REQ-005 SHALL have parameter blank_cycles, default 16, anti-ghosting cycles at the start of each slot.
REQ-006 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port value  input  w_value  binary value to display.
REQ-009 SHALL have port value_valid  input  1  load strobe; accepted only when ready = 1.
REQ-010 SHALL have port mode_dec  input  1  0 = hexadecimal, 1 = decimal; sampled with value.
REQ-011 SHALL have port lz_suppress  input  1  blank leading zeros; sampled with value.
REQ-012 SHALL have port dp_mask  input  w_digit  decimal point per digit; sampled at frame boundary.
REQ-013 SHALL have port blank_mask  input  w_digit  forced-blank per digit; sampled at frame boundary.
REQ-014 SHALL have port ready  output  1  high when a new value can be accepted.
REQ-015 SHALL have port overflow  output  1  last accepted value did not fit in w_digit digits.
REQ-016 SHALL have port abcdefgh  output  8  active-high segments, a = bit 7, dp (h) = bit 0.
REQ-017 SHALL have port digit  output  w_digit  active-high one-hot digit select, digit[0] = rightmost.

Function
REQ-018 Slot counter SHALL count 0..slot_cycles-1; at wrap, the slot index advances 0,1,...,w_digit-1,0; digit = 1 << index.
REQ-019 Frame boundary SHALL be the cycle the slot index wraps from w_digit-1 to 0.
REQ-020 abcdefgh SHALL be 0 during slot-counter values 0..blank_cycles-1, else the display-buffer glyph of the current index.
REQ-021 Conversion FSM states SHALL be IDLE, HEX, DEC, DONE; IDLE->HEX or IDLE->DEC on accepted value_valid.
REQ-022 HEX SHALL take 1 cycle: nibble i -> glyph i of the shadow buffer; then DONE.
REQ-023 DEC SHALL run double-dabble, one bit per cycle, exactly w_value cycles, then DONE.
REQ-024 DONE SHALL apply leading-zero suppression and overflow detection, write the shadow buffer, return to IDLE (1 cycle).
REQ-025 ready SHALL be low from the cycle after acceptance until the cycle DONE is exited; value_valid while ready = 0 SHALL be dropped.
REQ-026 Leading-zero suppression SHALL blank digits above the most significant non-zero digit; digit 0 always shown (value 0 shows "0").
REQ-027 Overflow (non-zero digit at positions >= w_digit) SHALL set overflow = 1 and fill the shadow with dash (0000_0010); otherwise overflow = 0.
REQ-028 Shadow buffer, dp_mask and blank_mask SHALL be copied into the display buffer only at a frame boundary; dp ORs bit 0, blank forces 0.
REQ-029 A shadow write coinciding with a frame boundary SHALL NOT be displayed until the following frame boundary.
REQ-030 Glyphs SHALL be 0..9, A..F (hex), dash, blank; A = 1110_1110, 0 = 1111_1100, 1 = 0110_0000, 3 = 1111_0010.

Reset
REQ-031 On rst low: digit = 1, abcdefgh = 0, ready = 1, overflow = 0, FSM = IDLE, counters = 0, shadow and display buffers all blank.
REQ-032 Reset mid-conversion SHALL abort it; the partial result SHALL never reach the shadow buffer.

Structure
REQ-033 Package seg7_pkg SHALL hold glyph constants, the conversion FSM state enum and a nibble-to-glyph function.
REQ-034 Double-dabble SHALL be the sub-module seg7_bin2bcd (start/done handshake, w_value and w_digit parameters, overflow output).

Verification (w_digit=4, w_value=12, slot_cycles=8, blank_cycles=2 unless stated)
REQ-035 Reset release -> digit 0001, 0010, 0100, 1000, 0001 every 8 cycles; abcdefgh = 0 throughout (buffers blank).
REQ-036 Hex 12'h1A3, lz_suppress = 1 -> after next frame boundary slots show 1111_0010, 1110_1110, 0110_0000, 0000_0000; first 2 cycles of each slot = 0.
REQ-037 Dec 999, lz_suppress = 0 -> ready low 14 cycles; shows 0,9,9,9; with lz_suppress = 1 digit 3 is blank.
REQ-038 w_digit=3, dec 4095 -> overflow = 1, all three digits 0000_0010.
REQ-039 value_valid for 7 then for 5 while busy -> second dropped; 7 displayed; dp_mask=0001 sets bit 0 only on digit 0.
REQ-040 rst low during DEC -> ready = 1 and digit = 0001 immediately (asynchronously); display remains blank.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table, conversion FSM states and sizing helpers shared by the seg7 display.
package seg7_pkg;
    typedef enum logic [1:0] {IDLE, HEX, DEC, DONE} conv_state_t;
    localparam logic [7:0] glyph_blank = 8'h00;
    localparam logic [7:0] glyph_dash = 8'h02;
    localparam logic [127:0] glyph_rom = 128'h8E9E7A9C3EEEF6FEE0BEB666F2DA60FC;
    function automatic logic [7:0] nibble_glyph(input logic [3:0] n);
        return glyph_rom[{n, 3'b000} +: 8];
    endfunction
    // one spare digit above the display keeps the overflow slice non-empty
    function automatic int bcd_digits(input int w_value, input int w_digit);
        int d = w_value * 3 / 10 + 1;
        return (d > w_digit ? d : w_digit) + 1;
    endfunction
endpackage

// File: rtl/seg7_mux_display_if.sv
// seg7_mux_display_if: value load handshake and conversion status.
interface seg7_mux_display_if #(parameter int w_value = 16);
    logic [w_value-1:0] value;
    logic value_valid, mode_dec, lz_suppress, ready, overflow;
    modport master(output value, value_valid, mode_dec, lz_suppress, input ready, overflow);
    modport slave(input value, value_valid, mode_dec, lz_suppress, output ready, overflow);
endinterface

// File: rtl/seg7_bin2bcd.sv
// seg7_bin2bcd: serial double-dabble, one input bit per cycle for w_value cycles after start.
module seg7_bin2bcd
    import seg7_pkg::*;
#(
    parameter int w_value = 16,
    parameter int w_digit = 8,
    localparam int n_bcd = bcd_digits(w_value, w_digit)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [w_value-1:0]   din,
    output logic [4*n_bcd-1:0]   bcd,
    output logic                 done,
    output logic                 overflow
);
    localparam int cnt_w = $clog2(w_value + 1);
    logic [w_value-1:0] bin;
    logic [cnt_w-1:0] cnt;
    logic [4*n_bcd-1:0] adj;
    always_comb begin
        adj = bcd;
        for (int i = 0; i < n_bcd; i++)
            adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            bin <= '0;
            bcd <= '0;
            cnt <= '0;
            done <= 1'b0;
        end else if (start) begin
            bin <= din;
            bcd <= '0;
            cnt <= cnt_w'(w_value);
            done <= 1'b0;
        end else begin
            done <= cnt == cnt_w'(1);
            if (cnt != '0) begin
                bcd <= {adj[4*n_bcd-2:0], bin[w_value-1]};
                bin <= bin << 1;
                cnt <= cnt - cnt_w'(1);
            end
        end
    assign overflow = |bcd[4*n_bcd-1:4*w_digit];
endmodule

// File: rtl/seg7_mux_display.sv
// seg7_mux_display: multiplexed 7-segment driver with hex/decimal conversion into a shadow
// buffer that is copied to the display buffer only at frame boundaries.
module seg7_mux_display
    import seg7_pkg::*;
#(
    parameter int clk_mhz = 50,
    parameter int w_digit = 8,
    parameter int w_value = 16,
    parameter int slot_cycles = 5000,
    parameter int blank_cycles = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_mux_display_if.slave     bus,
    input  logic [w_digit-1:0]    dp_mask,
    input  logic [w_digit-1:0]    blank_mask,
    output logic [7:0]            abcdefgh,
    output logic [w_digit-1:0]    digit
);
    localparam int n_bcd = bcd_digits(w_value, w_digit);
    localparam int cnt_w = $clog2(slot_cycles);
    localparam int idx_w = $clog2(w_digit);
    if (clk_mhz < 1 || w_digit < 2 || slot_cycles < blank_cycles + 2) begin : g_param_check
        $error("seg7_mux_display: invalid parameters");
    end
    conv_state_t state;
    logic ready_q, overflow_q, lz, ovf_r, accept, hex_ovf, b_done, b_ovf, wrap, last;
    logic [4*n_bcd-1:0] work, ext, b_bcd;
    logic [w_digit-1:0][7:0] shadow, shadow_next, disp;
    logic [cnt_w-1:0] cnt;
    logic [idx_w-1:0] idx;
    assign ext = (4*n_bcd)'(bus.value);
    assign hex_ovf = |ext[4*n_bcd-1:4*w_digit];
    assign accept = ready_q && bus.value_valid;
    assign bus.ready = ready_q;
    assign bus.overflow = overflow_q;
    seg7_bin2bcd #(.w_value(w_value), .w_digit(w_digit)) u_bin2bcd (
        .clk, .rst, .start(accept && bus.mode_dec), .din(bus.value),
        .bcd(b_bcd), .done(b_done), .overflow(b_ovf)
    );
    // a digit stays lit if it or any digit above it is non-zero; digit 0 is always lit
    always_comb begin
        shadow_next = '0;
        for (int i = 0; i < w_digit; i++)
            shadow_next[i] = ovf_r ? glyph_dash
                : (i == 0 || !lz || (work >> (4 * i)) != '0) ? nibble_glyph(work[4*i+:4]) : glyph_blank;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            ready_q <= 1'b1;
            overflow_q <= 1'b0;
            lz <= 1'b0;
            ovf_r <= 1'b0;
            work <= '0;
            shadow <= {w_digit{glyph_blank}};
        end else
            case (state)
                IDLE: if (accept) begin
                    state <= bus.mode_dec ? DEC : HEX;
                    ready_q <= 1'b0;
                    lz <= bus.lz_suppress;
                    work <= ext;
                    ovf_r <= hex_ovf;
                end
                HEX: state <= DONE;
                DEC: if (b_done) begin
                    state <= DONE;
                    work <= b_bcd;
                    ovf_r <= b_ovf;
                end
                DONE: begin
                    state <= IDLE;
                    ready_q <= 1'b1;
                    overflow_q <= ovf_r;
                    shadow <= shadow_next;
                end
                default: state <= IDLE;
            endcase
    assign wrap = cnt == cnt_w'(slot_cycles - 1);
    assign last = idx == idx_w'(w_digit - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
            disp <= {w_digit{glyph_blank}};
        end else begin
            cnt <= wrap ? '0 : cnt + cnt_w'(1);
            if (wrap)
                idx <= last ? '0 : idx + idx_w'(1);
            if (wrap && last)
                for (int i = 0; i < w_digit; i++)
                    disp[i] <= blank_mask[i] ? glyph_blank : shadow[i] | {7'b0, dp_mask[i]};
        end
    assign digit = w_digit'(1) << idx;
    assign abcdefgh = cnt < cnt_w'(blank_cycles) ? glyph_blank : disp[idx];
endmodule

// File: tb/tb_seg7_mux_display.sv
// tb_seg7_mux_display: directed checks of slot scan, hex/dec conversion, masks, overflow and reset.
module tb_seg7_mux_display;
    logic clk = 1'b0, rst = 1'b0;
    logic [3:0] dp4 = '0, blank4 = '0, dig4;
    logic [2:0] dp3 = '0, blank3 = '0, dig3;
    logic [7:0] seg4, seg3;
    int cyc, checks = 0, errors = 0;
    seg7_mux_display_if #(.w_value(12)) bus4 ();
    seg7_mux_display_if #(.w_value(12)) bus3 ();
    seg7_mux_display #(.w_digit(4), .w_value(12), .slot_cycles(8), .blank_cycles(2)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .dp_mask(dp4), .blank_mask(blank4),
        .abcdefgh(seg4), .digit(dig4)
    );
    seg7_mux_display #(.w_digit(3), .w_value(12), .slot_cycles(8), .blank_cycles(2)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .dp_mask(dp3), .blank_mask(blank3),
        .abcdefgh(seg3), .digit(dig3)
    );
    always #5 clk = ~clk;
    // cycles since reset release; equals the slot counter phase of both DUTs
    always @(posedge clk) cyc <= rst ? cyc + 1 : 0;
    initial begin
        #20000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic goto(input int k);
        for (int n = 0; n < 2000 && cyc != k; n++) @(negedge clk);
        if (cyc != k) begin
            errors++;
            $error("FAIL goto: cycle %0d expected %0d", cyc, k);
        end
    endtask
    task automatic send4(input logic [11:0] v, input logic dec, input logic lz);
        bus4.value = v;
        bus4.mode_dec = dec;
        bus4.lz_suppress = lz;
        bus4.value_valid = 1'b1;
    endtask
    initial begin
        bus4.value = '0; bus4.value_valid = 0; bus4.mode_dec = 0; bus4.lz_suppress = 0;
        bus3.value = '0; bus3.value_valid = 0; bus3.mode_dec = 0; bus3.lz_suppress = 0;
        repeat (3) @(negedge clk);
        check("rst_digit", dig4, 4'b0001);
        check("rst_seg", seg4, 8'h00);
        check("rst_ready", bus4.ready, 1'b1);
        check("rst_ovf", bus4.overflow, 1'b0);
        rst = 1'b1;
        for (int j = 0; j < 5; j++) begin
            goto(8 * j + 4);
            check($sformatf("scan_digit%0d", j), dig4, 4'b0001 << (j % 4));
            check($sformatf("scan_seg%0d", j), seg4, 8'h00);
        end
        goto(40);
        send4(12'h1A3, 1'b0, 1'b1);
        goto(41);
        bus4.value_valid = 1'b0;
        check("hex_busy", bus4.ready, 1'b0);
        goto(43);
        check("hex_ready", bus4.ready, 1'b1);
        check("hex_ovf", bus4.overflow, 1'b0);
        goto(50);
        check("hex_not_yet", seg4, 8'h00);
        goto(64);
        check("hex_blank_c0", seg4, 8'h00);
        goto(65);
        check("hex_blank_c1", seg4, 8'h00);
        goto(66);
        check("hex_d0", seg4, 8'hF2);
        goto(74);
        check("hex_d1", seg4, 8'hEE);
        goto(82);
        check("hex_d2", seg4, 8'h60);
        goto(90);
        check("hex_d3_lz", seg4, 8'h00);
        goto(96);
        send4(12'd999, 1'b1, 1'b0);
        goto(97);
        bus4.value_valid = 1'b0;
        check("dec_busy_first", bus4.ready, 1'b0);
        goto(110);
        check("dec_busy_last", bus4.ready, 1'b0);
        goto(111);
        check("dec_ready", bus4.ready, 1'b1);
        goto(130);
        check("dec_d0", seg4, 8'hF6);
        goto(138);
        check("dec_d1", seg4, 8'hF6);
        goto(146);
        check("dec_d2", seg4, 8'hF6);
        goto(154);
        check("dec_d3_zero", seg4, 8'hFC);
        goto(160);
        send4(12'd999, 1'b1, 1'b1);
        goto(161);
        bus4.value_valid = 1'b0;
        goto(194);
        check("declz_d0", seg4, 8'hF6);
        goto(210);
        check("declz_d2", seg4, 8'hF6);
        goto(218);
        check("declz_d3", seg4, 8'h00);
        goto(224);
        send4(12'd7, 1'b1, 1'b1);
        dp4 = 4'b0001;
        goto(225);
        send4(12'd5, 1'b1, 1'b1);
        check("drop_busy", bus4.ready, 1'b0);
        goto(227);
        bus4.value_valid = 1'b0;
        goto(240);
        check("drop_ready", bus4.ready, 1'b1);
        goto(258);
        check("dp_d0", seg4, 8'hE1);
        goto(260);
        blank4 = 4'b0001;
        goto(266);
        check("dp_d1", seg4, 8'h00);
        goto(290);
        check("blank_d0", seg4, 8'h00);
        goto(300);
        blank4 = 4'b0000;
        dp4 = 4'b0000;
        bus3.value = 12'd4095; bus3.mode_dec = 1'b1; bus3.lz_suppress = 1'b0; bus3.value_valid = 1'b1;
        goto(301);
        bus3.value_valid = 1'b0;
        check("ovf_busy", bus3.ready, 1'b0);
        goto(316);
        check("ovf_flag", bus3.overflow, 1'b1);
        check("ovf_other", bus4.overflow, 1'b0);
        goto(322);
        check("unmask_d0", seg4, 8'hE0);
        goto(338);
        check("ovf_d0", seg3, 8'h02);
        goto(346);
        check("ovf_d1", seg3, 8'h02);
        check("ovf_digit", dig3, 3'b010);
        goto(354);
        check("ovf_d2", seg3, 8'h02);
        goto(381);
        send4(12'h005, 1'b0, 1'b1);
        goto(382);
        bus4.value_valid = 1'b0;
        goto(386);
        check("frame_race_old", seg4, 8'hE0);
        goto(418);
        check("frame_race_new", seg4, 8'hB6);
        goto(420);
        send4(12'd999, 1'b1, 1'b0);
        goto(421);
        bus4.value_valid = 1'b0;
        goto(425);
        rst = 1'b0;
        #1;
        check("abort_ready", bus4.ready, 1'b1);
        check("abort_digit", dig4, 4'b0001);
        check("abort_seg", seg4, 8'h00);
        check("abort_ovf3", bus3.overflow, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        goto(34);
        check("abort_blank_d0", seg4, 8'h00);
        goto(42);
        check("abort_blank_d1", seg4, 8'h00);
        goto(44);
        check("abort_idle", bus4.ready, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
